// File: rtl/dmem_stall_ctrl.sv
// rtl/dmem_stall_ctrl.sv - data-memory access sequencer that stalls the pipeline until ack or timeout
// Optional build macro: DMEM_STALL_PERF_EN adds stall_cnt_o / access_cnt_o performance counters.
module dmem_stall_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WrData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] RDData_o,
    output logic              stall_o,
    output logic              err_o
`ifdef DMEM_STALL_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       access_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Timeout of zero means "wait forever"; TO_LAST is the last wait_cnt value before abort.
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              access_pending;

    assign access_pending = MemRead_i | MemWrite_i;

    // Stall covers the cycle the request is spotted in IDLE plus every ACCESS cycle; DONE releases it.
    always_comb begin
        stall_o = ((state_q == IDLE) && access_pending) || (state_q == ACCESS);
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rddata_d    = rddata_q;
        err_d       = err_q;
        wait_cnt_d  = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (access_pending) begin
                    // A store wins when both controls are high.
                    mem_addr_d  = Addr_i;
                    mem_wdata_d = WrData_i;
                    mem_we_d    = MemWrite_i;
                    mem_req_d   = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    // Ack beats a coincident timeout; stores return zero load data.
                    rddata_d  = mem_we_q ? '0 : mem_rdata_i;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
                    rddata_d  = '0;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DONE: begin
                // One non-stalled cycle lets MEM_WB capture RDData_o and the pipeline move on.
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

`ifdef DMEM_STALL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] access_cnt_q, access_cnt_d;

    // Performance counters: stalled cycles and completed accesses, both free-running modulo 2^32.
    always_comb begin
        stall_cnt_d  = stall_cnt_q + (stall_o ? 32'd1 : 32'd0);
        access_cnt_d = access_cnt_q;
        if ((state_q == ACCESS) && (state_d == DONE)) begin
            access_cnt_d = access_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            access_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            access_cnt_q <= access_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign access_cnt_o = access_cnt_q;
`endif

    // Sequencer state and registered outputs; reset abandons any outstanding memory access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rddata_q    <= '0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rddata_q    <= rddata_d;
            err_q       <= err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign RDData_o    = rddata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb/tb_dmem_stall_ctrl.sv - directed self-checking bench for dmem_stall_ctrl
module tb_dmem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        ack = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        rd1, wr1, rd2, wr2;
    logic        req1, we1, stall1, err1, req2, we2, stall2, err2;
    logic [31:0] maddr1, mwd1, rdo1, maddr2, mwd2, rdo2;
    logic        obs_req, obs_we, obs_stall, obs_err;
    logic [31:0] obs_addr, obs_wd, obs_rd;
`ifdef DMEM_STALL_PERF_EN
    logic [31:0] scnt1, acnt1, scnt2, acnt2;
`endif

    always #5 clk = ~clk;

    // sel steers the pipeline controls to the long-timeout unit (0) or the TIMEOUT=4 unit (1).
    assign rd1 = mem_read & ~sel;
    assign wr1 = mem_write & ~sel;
    assign rd2 = mem_read & sel;
    assign wr2 = mem_write & sel;
    assign obs_req   = sel ? req2 : req1;
    assign obs_we    = sel ? we2 : we1;
    assign obs_stall = sel ? stall2 : stall1;
    assign obs_err   = sel ? err2 : err1;
    assign obs_addr  = sel ? maddr2 : maddr1;
    assign obs_wd    = sel ? mwd2 : mwd1;
    assign obs_rd    = sel ? rdo2 : rdo1;

    dmem_stall_ctrl dut1 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1),
        .Addr_i(addr), .WrData_i(wdata), .mem_req_o(req1), .mem_we_o(we1),
        .mem_addr_o(maddr1), .mem_wdata_o(mwd1), .mem_ack_i(ack), .mem_rdata_i(rdata),
        .RDData_o(rdo1), .stall_o(stall1), .err_o(err1)
`ifdef DMEM_STALL_PERF_EN
        , .stall_cnt_o(scnt1), .access_cnt_o(acnt1)
`endif
    );

    dmem_stall_ctrl #(.TIMEOUT(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd2), .MemWrite_i(wr2),
        .Addr_i(addr), .WrData_i(wdata), .mem_req_o(req2), .mem_we_o(we2),
        .mem_addr_o(maddr2), .mem_wdata_o(mwd2), .mem_ack_i(ack), .mem_rdata_i(rdata),
        .RDData_o(rdo2), .stall_o(stall2), .err_o(err2)
`ifdef DMEM_STALL_PERF_EN
        , .stall_cnt_o(scnt2), .access_cnt_o(acnt2)
`endif
    );

    // Results of the most recent access driven by run_access.
    logic        r_done, r_first_req, r_we, r_stable, r_err;
    int          r_stalls, r_acc;
    logic [31:0] r_addr, r_wd, r_rd;

    // Drives one MEM-stage instruction from IDLE until its DONE cycle; ack_at=0 means never ack.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_at, input logic [31:0] rdv);
        r_done = 1'b0; r_stalls = 0; r_acc = 0; r_stable = 1'b1; r_first_req = 1'b0;
        r_addr = '0; r_we = 1'b0; r_wd = '0; r_rd = '0; r_err = 1'b0;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (c == 0) r_first_req = obs_req;
            if (obs_stall) r_stalls++;
            else if (r_stalls > 0) begin
                r_done = 1'b1; r_rd = obs_rd; r_err = obs_err;
            end
            if (obs_req) begin
                r_acc++;
                if (r_acc == 1) begin
                    r_addr = obs_addr; r_we = obs_we; r_wd = obs_wd;
                end else if (obs_addr !== r_addr || obs_we !== r_we || obs_wd !== r_wd) begin
                    r_stable = 1'b0;
                end
                if (r_acc == ack_at) begin
                    ack = 1'b1; rdata = rdv;
                end
            end
            @(posedge clk); #1;
            ack = 1'b0; rdata = '0;
            if (r_done) break;
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset;
        sel = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obs_req); end
        n_tests++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", obs_we); end
        n_tests++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", obs_addr); end
        n_tests++; if (obs_wd !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", obs_wd); end
        n_tests++; if (obs_rd !== 32'h0) begin n_fail++; $display("FAIL reset_rddata: got %h want 0", obs_rd); end
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", obs_err); end
        n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", obs_stall); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_immediate;
        sel = 1'b0;
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hCAFEF00D);
        n_tests++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL load_imm_done: got %b want 1", r_done); end
        n_tests++; if (r_stalls != 2) begin n_fail++; $display("FAIL load_imm_stalls: got %0d want 2", r_stalls); end
        n_tests++; if (r_addr !== 32'h40) begin n_fail++; $display("FAIL load_imm_addr: got %h want 40", r_addr); end
        n_tests++; if (r_we !== 1'b0) begin n_fail++; $display("FAIL load_imm_we: got %b want 0", r_we); end
        n_tests++; if (r_rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL load_imm_rddata: got %h want cafef00d", r_rd); end
        n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL load_imm_err: got %b want 0", r_err); end
    endtask

    task automatic test_store_delayed;
        sel = 1'b0;
        run_access(1'b0, 1'b1, 32'h10, 32'h12345678, 5, 32'hFFFF0000);
        n_tests++; if (r_stalls != 6) begin n_fail++; $display("FAIL store5_stalls: got %0d want 6", r_stalls); end
        n_tests++; if (r_acc != 5) begin n_fail++; $display("FAIL store5_access_cycles: got %0d want 5", r_acc); end
        n_tests++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL store5_we: got %b want 1", r_we); end
        n_tests++; if (r_wd !== 32'h12345678) begin n_fail++; $display("FAIL store5_wdata: got %h want 12345678", r_wd); end
        n_tests++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL store5_stable: got %b want 1", r_stable); end
        n_tests++; if (r_rd !== 32'h0) begin n_fail++; $display("FAIL store5_rddata: got %h want 0", r_rd); end
    endtask

    task automatic test_back_to_back;
        sel = 1'b0;
        run_access(1'b1, 1'b0, 32'h0, 32'h0, 1, 32'hA);
        n_tests++; if (r_rd !== 32'hA) begin n_fail++; $display("FAIL b2b_first_rddata: got %h want a", r_rd); end
        n_tests++; if (r_addr !== 32'h0) begin n_fail++; $display("FAIL b2b_first_addr: got %h want 0", r_addr); end
        run_access(1'b1, 1'b0, 32'h4, 32'h0, 1, 32'hB);
        n_tests++; if (r_first_req !== 1'b0) begin n_fail++; $display("FAIL b2b_no_reissue: got %b want 0", r_first_req); end
        n_tests++; if (r_addr !== 32'h4) begin n_fail++; $display("FAIL b2b_second_addr: got %h want 4", r_addr); end
        n_tests++; if (r_rd !== 32'hB) begin n_fail++; $display("FAIL b2b_second_rddata: got %h want b", r_rd); end
        n_tests++; if (r_stalls != 2) begin n_fail++; $display("FAIL b2b_second_stalls: got %0d want 2", r_stalls); end
        run_access(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 1, 32'h99);
        n_tests++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL both_high_we: got %b want 1", r_we); end
        n_tests++; if (r_rd !== 32'h0) begin n_fail++; $display("FAIL both_high_rddata: got %h want 0", r_rd); end
    endtask

    task automatic test_reset_late_ack;
        sel = 1'b0;
        mem_read = 1'b1; addr = 32'h20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL rst_access_req: got %b want 1", obs_req); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        #1;
        n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rst_abort_req: got %b want 0", obs_req); end
        n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL rst_abort_stall: got %b want 0", obs_stall); end
        n_tests++; if (obs_rd !== 32'h0) begin n_fail++; $display("FAIL rst_abort_rddata: got %h want 0", obs_rd); end
        @(posedge clk); #1;
        ack = 1'b1; rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        ack = 1'b0; rdata = '0;
        #1;
        n_tests++; if (obs_rd !== 32'h0) begin n_fail++; $display("FAIL late_ack_rddata: got %h want 0", obs_rd); end
        n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL late_ack_req: got %b want 0", obs_req); end
        n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL late_ack_stall: got %b want 0", obs_stall); end
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL late_ack_err: got %b want 0", obs_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        sel = 1'b1;
        run_access(1'b1, 1'b0, 32'h30, 32'h0, 4, 32'h77);
        n_tests++; if (r_acc != 4) begin n_fail++; $display("FAIL ack_at_limit_cycles: got %0d want 4", r_acc); end
        n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL ack_at_limit_err: got %b want 0", r_err); end
        n_tests++; if (r_rd !== 32'h77) begin n_fail++; $display("FAIL ack_at_limit_rddata: got %h want 77", r_rd); end
        run_access(1'b1, 1'b0, 32'h34, 32'h0, 0, 32'h0);
        n_tests++; if (r_done !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %b want 1", r_done); end
        n_tests++; if (r_acc != 4) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 4", r_acc); end
        n_tests++; if (r_stalls != 5) begin n_fail++; $display("FAIL timeout_stalls: got %0d want 5", r_stalls); end
        n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", r_err); end
        n_tests++; if (r_rd !== 32'h0) begin n_fail++; $display("FAIL timeout_rddata: got %h want 0", r_rd); end
        run_access(1'b1, 1'b0, 32'h38, 32'h0, 1, 32'h55);
        n_tests++; if (r_rd !== 32'h55) begin n_fail++; $display("FAIL after_timeout_rddata: got %h want 55", r_rd); end
        n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL after_timeout_sticky_err: got %b want 1", r_err); end
        sel = 1'b0;
    endtask

`ifdef DMEM_STALL_PERF_EN
    task automatic test_perf;
        sel = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hCAFEF00D);
        run_access(1'b0, 1'b1, 32'h10, 32'h12345678, 5, 32'h0);
        n_tests++; if (scnt1 !== 32'd8) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d want 8", scnt1); end
        n_tests++; if (acnt1 !== 32'd2) begin n_fail++; $display("FAIL perf_access_cnt: got %0d want 2", acnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_immediate();
        test_store_delayed();
        test_back_to_back();
        test_reset_late_ack();
        test_timeout();
`ifdef DMEM_STALL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
Sequences every data-memory access of the 5-stage pipeline against a variable-latency data memory.
- Sits between the EX/MEM pipeline register and the data memory.
- Holds the pipeline (including MEM_WB) via stall_o until the memory acknowledges.
- Supplies load data to MEM_WB RDData_i.
- Bounds each access with a timeout that raises a sticky error.

Parameters:
DATA_W, 32, data and address width
TIMEOUT, 255, max ACCESS cycles without ack before abort; 0 disables the timeout
TO_W, 8, wait counter width; must hold TIMEOUT

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
MemRead_i  in  1  load pending in MEM stage (EX/MEM control)
MemWrite_i  in  1  store pending in MEM stage
Addr_i  in  DATA_W  ALU result / memory address
WrData_i  in  DATA_W  store data
mem_req_o  out  1  request to data memory
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  DATA_W  latched address
mem_wdata_o  out  DATA_W  latched store data
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
RDData_o  out  DATA_W  load result to MEM_WB RDData_i
stall_o  out  1  stall to PC, IF/ID, ID/EX, EX/MEM, MEM_WB
err_o  out  1  sticky timeout flag

Behaviour:
Interface:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, RDData_o, err_o, wait_cnt all 0. stall_o is therefore 0.

State machine: IDLE, ACCESS, DONE.
- All outputs except stall_o are registered.
- stall_o is combinational: (IDLE & (MemRead_i | MemWrite_i)) | ACCESS.
- IDLE, with MemRead_i or MemWrite_i:
  - Latch Addr_i, WrData_i and mem_we_o = MemWrite_i.
  - Clear wait_cnt and go to ACCESS.
  - MemWrite_i wins if both inputs are high (access is a write).
- IDLE, otherwise: stay; stall_o = 0.
- ACCESS: mem_req_o = 1; address, data and we are held stable.
  - On mem_ack_i: RDData_o <= mem_we_o ? 0 : mem_rdata_i; go to DONE.
  - On TIMEOUT != 0 and wait_cnt == TIMEOUT-1 with no ack: RDData_o <= 0, err_o <= 1, go to DONE.
  - Otherwise: wait_cnt increments.
- DONE: mem_req_o = 0; stall_o = 0, so the pipeline advances this cycle and MEM_WB captures RDData_o. Next state IDLE unconditionally.
  - DONE exists so the instruction just serviced is not re-issued.

Latency:
- Ack in the first ACCESS cycle gives 2 stall cycles; DONE is the 3rd cycle of the access.
- In general, stall cycles = 1 + ACCESS cycles.

Boundary conditions:
- mem_ack_i in IDLE or DONE is ignored and has no effect.
- Ack coincident with the timeout cycle: the ack wins, and err_o is not set.
- rst_i during ACCESS: all registers clear at that edge, and stall_o drops once IDLE is entered. The outstanding memory transaction is abandoned, and a late ack is ignored.
- err_o is cleared only by rst_i.
- RDData_o holds its last value until the next completion.
- wait_cnt saturates and never wraps: the timeout check precedes the increment.

Optional Feature:
DMEM_STALL_PERF_EN
- Defined:
  - Adds output port stall_cnt_o [31:0], reset to 0.
  - Increments on every cycle where stall_o = 1 and wraps modulo 2^32.
  - Adds output port access_cnt_o [31:0], which increments on each entry to DONE.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Load, ack immediate: MemRead_i=1, Addr_i=0x40 in IDLE; ack with rdata=0xCAFEF00D in 1st ACCESS cycle -> mem_addr_o=0x40, mem_we_o=0, stall_o high exactly 2 cycles, RDData_o=0xCAFEF00D in DONE, err_o=0.
- Store, ack delayed: MemWrite_i=1, Addr_i=0x10, WrData_i=0x12345678; ack after 5 ACCESS cycles -> mem_we_o=1, mem_wdata_o=0x12345678 stable throughout, stall_o high 6 cycles, RDData_o=0.
- Timeout: TIMEOUT=4, MemRead_i=1, no ack -> exactly 4 ACCESS cycles, then DONE with err_o=1 and RDData_o=0. A later load with immediate ack completes normally with err_o still 1.
- Reset and late ack: assert rst_i in the 2nd ACCESS cycle -> next cycle IDLE, mem_req_o=0, stall_o=0. A stray mem_ack_i 2 cycles later changes nothing.
- Back-to-back: loads to 0x0 then 0x4 on consecutive instructions, acks with 0xA and 0xB -> two separate DONE cycles, RDData_o=0xA then 0xB, no re-issue of 0x0. Both inputs high together gives a write.
- With DMEM_STALL_PERF_EN defined: the load-immediate case followed by the store-5 case -> stall_cnt_o=8, access_cnt_o=2.
